// File: rtl/mdma_ecc_sdp_ram.sv
// Simple-dual-port RAM with extended-Hamming SECDED protection, configurable
// read latency, per-read error flags, saturating error counters and first-error capture.
module mdma_ecc_sdp_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              inj_sbe,
  input  logic              inj_dbe,
  input  logic              ren,
  input  logic [ADDR_W-1:0] radr,
  output logic              rvld,
  output logic [DATA_W-1:0] rdat,
  output logic              rsbe,
  output logic              rdbe,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt,
  output logic              err_vld,
  output logic [ADDR_W-1:0] err_adr,
  output logic              err_dbe
);

  function automatic int calc_ecc_w(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p + 1;
  endfunction

  localparam int ECC_W = calc_ecc_w(DATA_W);
  localparam int CW_W  = DATA_W + ECC_W;
  localparam int SYN_W = ECC_W - 1;

  // Data bits occupy the non-power-of-two positions from 3 upwards, LSB first.
  function automatic logic [CW_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic            par;
    int              di;
    cw = '0;
    di = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[di];
        di++;
      end
    end
    for (int k = 0; k < SYN_W; k++) begin
      par = 1'b0;
      for (int i = 1; i < CW_W; i++) begin
        if (((i >> k) & 1) == 1) par = par ^ cw[i];
      end
      cw[1 << k] = par;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] ecc_extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                di;
    d  = '0;
    di = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[di] = cw[i];
        di++;
      end
    end
    return d;
  endfunction

  logic [CW_W-1:0]   mem [DEPTH];
  logic [CW_W-1:0]   wr_cw;
  logic              s1_vld_d, s1_vld_q;
  logic [ADDR_W-1:0] s1_adr_d, s1_adr_q;
  logic [CW_W-1:0]   s1_cw_d, s1_cw_q;

  always_comb begin
    s1_vld_d = ren;
    s1_adr_d = radr;
    s1_cw_d  = mem[radr];
    wr_cw    = ecc_encode(wdat);
    if (inj_dbe)      wr_cw[2:1] = ~wr_cw[2:1];
    else if (inj_sbe) wr_cw[1]   = ~wr_cw[1];
  end

  // Array and its read register are not reset; the nonblocking write gives read-first.
  always_ff @(posedge clk) begin
    if (!rst && wen) mem[wadr] <= wr_cw;
    s1_cw_q <= s1_cw_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_adr_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_adr_q <= s1_adr_d;
    end
  end

  logic [SYN_W-1:0]  syn;
  logic              par;
  logic [CW_W-1:0]   fix_cw;
  logic [DATA_W-1:0] dec_dat;
  logic              dec_sbe, dec_dbe;

  always_comb begin
    syn = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (s1_cw_q[i]) syn = syn ^ SYN_W'(i);
    end
    par     = ^s1_cw_q;
    fix_cw  = s1_cw_q;
    dec_sbe = 1'b0;
    dec_dbe = 1'b0;
    if (syn != '0) begin
      if (!par || int'(syn) >= CW_W) begin
        dec_dbe = 1'b1;
      end else begin
        fix_cw[syn] = ~fix_cw[syn];
        dec_sbe     = 1'b1;
      end
    end else if (par) begin
      dec_sbe = 1'b1;
    end
    dec_dat = ecc_extract(fix_cw);
  end

  logic              out_vld, out_sbe, out_dbe;
  logic [DATA_W-1:0] out_dat;
  logic [ADDR_W-1:0] out_adr;

  if (RD_LAT == 1) begin : g_lat1
    assign out_vld = s1_vld_q;
    assign out_sbe = dec_sbe;
    assign out_dbe = dec_dbe;
    assign out_dat = dec_dat;
    assign out_adr = s1_adr_q;
  end else begin : g_lat_reg
    logic              s2_vld_q, s2_sbe_q, s2_dbe_q;
    logic [DATA_W-1:0] s2_dat_q;
    logic [ADDR_W-1:0] s2_adr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_sbe_q <= 1'b0;
        s2_dbe_q <= 1'b0;
        s2_dat_q <= '0;
        s2_adr_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        s2_sbe_q <= dec_sbe;
        s2_dbe_q <= dec_dbe;
        s2_dat_q <= dec_dat;
        s2_adr_q <= s1_adr_q;
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      assign out_vld = s2_vld_q;
      assign out_sbe = s2_sbe_q;
      assign out_dbe = s2_dbe_q;
      assign out_dat = s2_dat_q;
      assign out_adr = s2_adr_q;
    end else begin : g_lat3
      logic              s3_vld_q, s3_sbe_q, s3_dbe_q;
      logic [DATA_W-1:0] s3_dat_q;
      logic [ADDR_W-1:0] s3_adr_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s3_vld_q <= 1'b0;
          s3_sbe_q <= 1'b0;
          s3_dbe_q <= 1'b0;
          s3_dat_q <= '0;
          s3_adr_q <= '0;
        end else begin
          s3_vld_q <= s2_vld_q;
          s3_sbe_q <= s2_sbe_q;
          s3_dbe_q <= s2_dbe_q;
          s3_dat_q <= s2_dat_q;
          s3_adr_q <= s2_adr_q;
        end
      end

      assign out_vld = s3_vld_q;
      assign out_sbe = s3_sbe_q;
      assign out_dbe = s3_dbe_q;
      assign out_dat = s3_dat_q;
      assign out_adr = s3_adr_q;
    end
  end

  assign rvld = out_vld;
  assign rdat = out_vld ? out_dat : '0;
  assign rsbe = out_vld & out_sbe;
  assign rdbe = out_vld & out_dbe;

  logic [CNT_W-1:0]  sbe_cnt_d, sbe_cnt_q, dbe_cnt_d, dbe_cnt_q;
  logic              err_vld_d, err_vld_q, err_dbe_d, err_dbe_q;
  logic [ADDR_W-1:0] err_adr_d, err_adr_q;

  // A clear in the same cycle as an error event discards that event entirely.
  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    err_vld_d = err_vld_q;
    err_adr_d = err_adr_q;
    err_dbe_d = err_dbe_q;
    if (clr_cnt) begin
      sbe_cnt_d = '0;
      dbe_cnt_d = '0;
      err_vld_d = 1'b0;
      err_adr_d = '0;
      err_dbe_d = 1'b0;
    end else begin
      if (rsbe && sbe_cnt_q != '1) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
      if (rdbe && dbe_cnt_q != '1) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
      if (!err_vld_q && (rsbe || rdbe)) begin
        err_vld_d = 1'b1;
        err_adr_d = out_adr;
        err_dbe_d = rdbe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
      err_vld_q <= 1'b0;
      err_adr_q <= '0;
      err_dbe_q <= 1'b0;
    end else begin
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
      err_vld_q <= err_vld_d;
      err_adr_q <= err_adr_d;
      err_dbe_q <= err_dbe_d;
    end
  end

  assign sbe_cnt = sbe_cnt_q;
  assign dbe_cnt = dbe_cnt_q;
  assign err_vld = err_vld_q;
  assign err_adr = err_adr_q;
  assign err_dbe = err_dbe_q;

endmodule

// File: tb/tb_mdma_ecc_sdp_ram.sv
// Randomised self-checking bench for mdma_ecc_sdp_ram; the main instance uses
// RD_LAT=2 with 4-bit counters, two side instances cover RD_LAT=1 and RD_LAT=3.
module tb_mdma_ecc_sdp_ram;
  localparam int DW      = 64;
  localparam int DEP     = 512;
  localparam int AW      = 9;
  localparam int CW      = 4;
  localparam int LAT     = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, wen, ren, inj_sbe, inj_dbe, clr_cnt;
  logic [AW-1:0] wadr, radr;
  logic [DW-1:0] wdat;

  logic          rvld, rsbe, rdbe, err_vld, err_dbe;
  logic [DW-1:0] rdat;
  logic [CW-1:0] sbe_cnt, dbe_cnt;
  logic [AW-1:0] err_adr;

  logic          rvld1, rsbe1, rdbe1, err_vld1, err_dbe1;
  logic [DW-1:0] rdat1;
  logic [15:0]   sbe_cnt1, dbe_cnt1;
  logic [AW-1:0] err_adr1;

  logic          rvld3, rsbe3, rdbe3, err_vld3, err_dbe3;
  logic [DW-1:0] rdat3;
  logic [15:0]   sbe_cnt3, dbe_cnt3;
  logic [AW-1:0] err_adr3;

  mdma_ecc_sdp_ram #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wen(wen), .wadr(wadr), .wdat(wdat), .inj_sbe(inj_sbe),
    .inj_dbe(inj_dbe), .ren(ren), .radr(radr), .rvld(rvld), .rdat(rdat), .rsbe(rsbe),
    .rdbe(rdbe), .clr_cnt(clr_cnt), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
    .err_vld(err_vld), .err_adr(err_adr), .err_dbe(err_dbe));

  mdma_ecc_sdp_ram #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .wen(wen), .wadr(wadr), .wdat(wdat), .inj_sbe(inj_sbe),
    .inj_dbe(inj_dbe), .ren(ren), .radr(radr), .rvld(rvld1), .rdat(rdat1), .rsbe(rsbe1),
    .rdbe(rdbe1), .clr_cnt(clr_cnt), .sbe_cnt(sbe_cnt1), .dbe_cnt(dbe_cnt1),
    .err_vld(err_vld1), .err_adr(err_adr1), .err_dbe(err_dbe1));

  mdma_ecc_sdp_ram #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .wen(wen), .wadr(wadr), .wdat(wdat), .inj_sbe(inj_sbe),
    .inj_dbe(inj_dbe), .ren(ren), .radr(radr), .rvld(rvld3), .rdat(rdat3), .rsbe(rsbe3),
    .rdbe(rdbe3), .clr_cnt(clr_cnt), .sbe_cnt(sbe_cnt3), .dbe_cnt(dbe_cnt3),
    .err_vld(err_vld3), .err_adr(err_adr3), .err_dbe(err_dbe3));

  always #5 clk = ~clk;

  // Reference model: stored data plus the error kind injected on the last write
  // (0 clean, 1 single, 2 double), and the expected counters/capture.
  logic [DW-1:0] m_dat [DEP];
  int            m_err [DEP];
  int            m_sbe, m_dbe, m_ea;
  bit            m_ev, m_ed;
  int            checks = 0;
  int            failures = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_sbe = 0; m_dbe = 0; m_ev = 0; m_ea = 0; m_ed = 0;
  endtask

  task automatic model_event(input int a);
    if (m_err[a] == 1 && m_sbe < CNT_MAX) m_sbe++;
    if (m_err[a] == 2 && m_dbe < CNT_MAX) m_dbe++;
    if (m_err[a] != 0 && !m_ev) begin
      m_ev = 1; m_ea = a; m_ed = (m_err[a] == 2);
    end
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    model_clear();
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d, input logic s, input logic b);
    wen = 1'b1; wadr = AW'(a); wdat = d; inj_sbe = s; inj_dbe = b;
    step();
    wen = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
    m_dat[a] = d;
    m_err[a] = b ? 2 : (s ? 1 : 0);
  endtask

  // Issues one read and returns what the main instance shows when rvld first rises.
  task automatic read_word(input int a, output logic [DW-1:0] d, output logic s,
                           output logic b, output int lat);
    bit seen;
    seen = 0; lat = -1; d = '0; s = 1'b0; b = 1'b0;
    ren = 1'b1; radr = AW'(a);
    for (int k = 1; k <= 8; k++) begin
      if (!seen) begin
        step();
        ren = 1'b0; wen = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0;
        if (rvld === 1'b1) begin
          seen = 1; lat = k; d = rdat; s = rsbe; b = rdbe;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; ren = 1'b0; inj_sbe = 1'b0; inj_dbe = 1'b0; clr_cnt = 1'b0;
    wadr = '0; radr = '0; wdat = '0;
    repeat (3) step();
    checks++; if (rvld !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvld got=%0h exp=0", rvld); end
    checks++; if (rdat !== '0) begin failures++; $display("[TB] FAIL reset_rdat got=%0h exp=0", rdat); end
    checks++; if ({rsbe, rdbe} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%0b exp=00", {rsbe, rdbe}); end
    checks++; if ({sbe_cnt, dbe_cnt} !== '0) begin failures++; $display("[TB] FAIL reset_cnt got=%0h/%0h exp=0/0", sbe_cnt, dbe_cnt); end
    checks++; if ({err_vld, err_adr, err_dbe} !== '0) begin failures++; $display("[TB] FAIL reset_capture got=%0b/%0h/%0b exp=0/0/0", err_vld, err_adr, err_dbe); end
    checks++;
    if ({rvld1, rsbe1, rdbe1, rdat1, sbe_cnt1, dbe_cnt1, err_vld1, err_adr1, err_dbe1} !== '0 ||
        {rvld3, rsbe3, rdbe3, rdat3, sbe_cnt3, dbe_cnt3, err_vld3, err_adr3, err_dbe3} !== '0) begin
      failures++; $display("[TB] FAIL reset_side_instances got=%0b/%0b exp=0/0", rvld1, rvld3);
    end
    rst = 1'b0;
    step();
    model_clear();
  endtask

  task automatic test_clean_read();
    logic [DW-1:0] d; logic s, b; int lat;
    write_word(5, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    read_word(5, d, s, b, lat);
    step();
    checks++; if (lat !== LAT) begin failures++; $display("[TB] FAIL clean_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (d !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("[TB] FAIL clean_rdat got=%0h exp=deadbeef01234567", d); end
    checks++; if ({s, b} !== 2'b00) begin failures++; $display("[TB] FAIL clean_flags got=%0b exp=00", {s, b}); end
    checks++; if ({sbe_cnt, dbe_cnt, err_vld} !== '0) begin failures++; $display("[TB] FAIL clean_cnt got=%0h/%0h/%0b exp=0/0/0", sbe_cnt, dbe_cnt, err_vld); end
  endtask

  task automatic test_sbe();
    logic [DW-1:0] d; logic s, b; int lat;
    clear_counters();
    write_word(511, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      read_word(511, d, s, b, lat);
      checks++; if (d !== 64'hA5A5_A5A5_A5A5_A5A5) begin failures++; $display("[TB] FAIL sbe_rdat[%0d] got=%0h exp=a5a5a5a5a5a5a5a5", n, d); end
      checks++; if ({s, b} !== 2'b10) begin failures++; $display("[TB] FAIL sbe_flags[%0d] got=%0b exp=10", n, {s, b}); end
      model_event(511);
    end
    step();
    checks++; if (sbe_cnt !== CW'(m_sbe)) begin failures++; $display("[TB] FAIL sbe_cnt got=%0d exp=%0d", sbe_cnt, m_sbe); end
    checks++;
    if ({err_vld, err_adr, err_dbe} !== {1'b1, AW'(511), 1'b0}) begin
      failures++; $display("[TB] FAIL sbe_capture got=%0b/%0d/%0b exp=1/511/0", err_vld, err_adr, err_dbe);
    end
  endtask

  task automatic test_dbe();
    logic [DW-1:0] d; logic s, b; int lat;
    clear_counters();
    write_word(7, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
    read_word(7, d, s, b, lat);
    model_event(7);
    step();
    checks++; if ({s, b} !== 2'b01) begin failures++; $display("[TB] FAIL dbe_flags got=%0b exp=01", {s, b}); end
    checks++; if (d !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("[TB] FAIL dbe_raw_rdat got=%0h exp=0123456789abcdef", d); end
    checks++; if (dbe_cnt !== CW'(m_dbe)) begin failures++; $display("[TB] FAIL dbe_cnt got=%0d exp=%0d", dbe_cnt, m_dbe); end
    read_word(511, d, s, b, lat);
    model_event(511);
    step();
    checks++; if (s !== 1'b1) begin failures++; $display("[TB] FAIL dbe_later_sbe got=%0b exp=1", s); end
    checks++;
    if ({err_vld, err_adr, err_dbe} !== {m_ev, AW'(m_ea), m_ed}) begin
      failures++; $display("[TB] FAIL dbe_capture got=%0b/%0d/%0b exp=%0b/%0d/%0b", err_vld, err_adr, err_dbe, m_ev, m_ea, m_ed);
    end
  endtask

  task automatic test_read_first();
    logic [DW-1:0] d; logic s, b; int lat;
    write_word(3, 64'h2, 1'b0, 1'b0);
    wen = 1'b1; wadr = 9'd3; wdat = 64'h1;
    read_word(3, d, s, b, lat);
    m_dat[3] = 64'h1; m_err[3] = 0;
    checks++; if (d !== 64'h2 || lat !== LAT) begin failures++; $display("[TB] FAIL read_first_old got=%0h exp=2", d); end
    read_word(3, d, s, b, lat);
    checks++; if (d !== 64'h1) begin failures++; $display("[TB] FAIL read_first_new got=%0h exp=1", d); end
  endtask

  task automatic test_latency();
    logic [DW-1:0] d, d1, d2, d3;
    int f1, f2, f3, n1, n2, n3;
    logic e1, e2, e3;
    d = {$urandom, $urandom};
    write_word(20, d, 1'b0, 1'b0);
    f1 = -1; f2 = -1; f3 = -1; n1 = 0; n2 = 0; n3 = 0;
    d1 = '0; d2 = '0; d3 = '0; e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
    ren = 1'b1; radr = 9'd20;
    for (int k = 1; k <= 6; k++) begin
      step();
      ren = 1'b0;
      if (rvld1 === 1'b1) begin n1++; if (f1 < 0) begin f1 = k; d1 = rdat1; e1 = rsbe1 | rdbe1; end end
      if (rvld === 1'b1) begin n2++; if (f2 < 0) begin f2 = k; d2 = rdat; e2 = rsbe | rdbe; end end
      if (rvld3 === 1'b1) begin n3++; if (f3 < 0) begin f3 = k; d3 = rdat3; e3 = rsbe3 | rdbe3; end end
    end
    checks++; if (f1 !== 1) begin failures++; $display("[TB] FAIL lat1_cycle got=%0d exp=1", f1); end
    checks++; if (f2 !== LAT) begin failures++; $display("[TB] FAIL lat2_cycle got=%0d exp=%0d", f2, LAT); end
    checks++; if (f3 !== 3) begin failures++; $display("[TB] FAIL lat3_cycle got=%0d exp=3", f3); end
    checks++; if (n1 !== 1 || n2 !== 1 || n3 !== 1) begin failures++; $display("[TB] FAIL lat_pulse_count got=%0d/%0d/%0d exp=1/1/1", n1, n2, n3); end
    checks++;
    if (d1 !== d || d2 !== d || d3 !== d || {e1, e2, e3} !== 3'b000) begin
      failures++; $display("[TB] FAIL lat_rdat got=%0h/%0h/%0h exp=%0h", d1, d2, d3, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] bb [4];
    logic [DW-1:0] d; logic s, b; int lat, got;
    for (int i = 0; i < 4; i++) begin
      bb[i] = {$urandom, $urandom};
      write_word(100 + i, bb[i], 1'b0, 1'b0);
    end
    got = 0;
    ren = 1'b1; radr = 9'd100;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k < 4) radr = AW'(100 + k);
      else ren = 1'b0;
      if (rvld === 1'b1) begin
        checks++;
        if (got >= 4) begin
          failures++; $display("[TB] FAIL b2b_extra got=%0d exp=4", got + 1);
        end else if (rdat !== bb[got] || k != LAT + got) begin
          failures++; $display("[TB] FAIL b2b_result[%0d] got=%0h@%0d exp=%0h@%0d", got, rdat, k, bb[got], LAT + got);
        end
        got++;
      end
    end
    checks++; if (got !== 4) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=4", got); end

    // Reset lands on the third read; reads and a write during reset must vanish.
    ren = 1'b1; radr = 9'd100;
    step();
    radr = 9'd101;
    step();
    radr = 9'd102; rst = 1'b1; wen = 1'b1; wadr = 9'd3; wdat = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    radr = 9'd103;
    model_clear();
    checks++; if ({rvld, rvld1, rvld3} !== 3'b000) begin failures++; $display("[TB] FAIL rst_flush_rvld got=%0b exp=000", {rvld, rvld1, rvld3}); end
    checks++; if ({rdat, rsbe, rdbe} !== '0) begin failures++; $display("[TB] FAIL rst_flush_data got=%0h/%0b/%0b exp=0/0/0", rdat, rsbe, rdbe); end
    checks++;
    if ({sbe_cnt, dbe_cnt, err_vld, err_adr, err_dbe} !== '0) begin
      failures++; $display("[TB] FAIL rst_flush_status got=%0h/%0h/%0b/%0h/%0b exp=0", sbe_cnt, dbe_cnt, err_vld, err_adr, err_dbe);
    end
    step();
    rst = 1'b0; ren = 1'b0; wen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if ({rvld, rvld1, rvld3} !== 3'b000) begin failures++; $display("[TB] FAIL rst_no_rvld[%0d] got=%0b exp=000", k, {rvld, rvld1, rvld3}); end
      step();
    end
    read_word(3, d, s, b, lat);
    checks++; if (d !== m_dat[3] || lat !== LAT) begin failures++; $display("[TB] FAIL rst_write_ignored got=%0h exp=%0h", d, m_dat[3]); end
  endtask

  task automatic test_random();
    int            wl[$];
    int            a, r, lat;
    logic [DW-1:0] d;
    logic          s, b;
    clear_counters();
    for (int n = 0; n < 24; n++) begin
      a = 200 + int'($urandom_range(0, 31));
      r = int'($urandom_range(0, 3));
      write_word(a, {$urandom, $urandom}, r == 2, r == 3);
      wl.push_back(a);
    end
    for (int n = 0; n < 24; n++) begin
      a = wl[$urandom_range(0, wl.size() - 1)];
      read_word(a, d, s, b, lat);
      checks++;
      if (d !== m_dat[a] || s !== (m_err[a] == 1) || b !== (m_err[a] == 2) || lat !== LAT) begin
        failures++; $display("[TB] FAIL rand_read[%0d] adr=%0d got=%0h/%0b%0b exp=%0h/kind%0d", n, a, d, s, b, m_dat[a], m_err[a]);
      end
      model_event(a);
    end
    step();
    checks++;
    if (sbe_cnt !== CW'(m_sbe) || dbe_cnt !== CW'(m_dbe)) begin
      failures++; $display("[TB] FAIL rand_counters got=%0d/%0d exp=%0d/%0d", sbe_cnt, dbe_cnt, m_sbe, m_dbe);
    end
    checks++;
    if (err_vld !== m_ev || (m_ev && (err_adr !== AW'(m_ea) || err_dbe !== m_ed))) begin
      failures++; $display("[TB] FAIL rand_capture got=%0b/%0d/%0b exp=%0b/%0d/%0b", err_vld, err_adr, err_dbe, m_ev, m_ea, m_ed);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d; logic s, b; int lat;
    clear_counters();
    for (int n = 0; n < 20; n++) begin
      read_word(511, d, s, b, lat);
      model_event(511);
    end
    step();
    checks++; if (sbe_cnt !== CW'(m_sbe) || m_sbe != CNT_MAX) begin failures++; $display("[TB] FAIL sat_hold got=%0h exp=%0h", sbe_cnt, CNT_MAX); end
    read_word(511, d, s, b, lat);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    model_clear();
    checks++; if (s !== 1'b1) begin failures++; $display("[TB] FAIL sat_clr_event got=%0b exp=1", s); end
    checks++; if (sbe_cnt !== '0 || err_vld !== 1'b0) begin failures++; $display("[TB] FAIL sat_clr_wins got=%0h/%0b exp=0/0", sbe_cnt, err_vld); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    test_reset();
    test_clean_read();
    test_sbe();
    test_dbe();
    test_read_first();
    test_latency();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
